mbox_ebox_resp: RTL and testbench
=================================

Name: mbox_ebox_resp

Overview:
- MBOX-side responder for EBOX memory references. Accepts single-word read/write requests on the EBOX request interface and answers with data, a response strobe, a T0 acknowledge and a retry indication.
- Contains a small direct-mapped, write-through word cache.
- Misses and writes go to a downstream memory port with a req/ack handshake. A no-ack timeout flags a non-existent-memory error.

Parameters:
- LINES, 16, number of direct-mapped cache words; power of two, at least 2.
- NXM_TIMEOUT, 63, number of memReq cycles without memAck before the NXM abort.

Ports:
- clk  in  1  system clock.
- CROBAR_N  in  1  reset; synchronous, active-low.
- EBOX_REQ  in  1  request strobe; a one-cycle pulse.
- EBOX_VMA  in  23  word address [13:35].
- eboxRead  in  1  read request.
- eboxWrite  in  1  write request.
- cacheDataWrite  in  36  write data [0:35].
- cacheDataRead  out  36  read data [0:35].
- mboxRespIn  out  1  response strobe.
- cshEBOXT0  out  1  request-accepted pulse.
- cshEBOXRetry  out  1  request-rejected pulse.
- nxmErr  out  1  sticky non-existent-memory flag.
- nxmClr  in  1  clears nxmErr.
- memReq  out  1  downstream request.
- memWrite  out  1  downstream write qualifier.
- memAdr  out  23  downstream address.
- memDataOut  out  36  downstream write data.
- memDataIn  in  36  downstream read data.
- memAck  in  1  downstream completion.

Behaviour:
- Reset, applied on any clk edge with CROBAR_N=0, including mid-operation:
  - state returns to IDLE and all valid bits clear.
  - every output is 0, including cacheDataRead and memAdr.
  - the timeout counter is 0 and any in-flight request is abandoned with no response.
- Address split:
  - index = low log2(LINES) bits of EBOX_VMA.
  - tag = the remaining high bits.
- States: IDLE, LOOKUP, MEM, RESP.
- IDLE:
  - A valid request is EBOX_REQ=1 with exactly one of eboxRead/eboxWrite set. It is latched (address, data, op) and the state goes to LOOKUP. cshEBOXT0=1 for exactly the next cycle.
  - EBOX_REQ with both or neither op bit set is not accepted. cshEBOXRetry=1 for the next cycle.
- LOOKUP:
  - Read hit (valid and tag equal): cacheDataRead is loaded from the line and the state goes to RESP.
  - Read miss or any write: the state goes to MEM.
- MEM:
  - memReq=1 with memAdr, memWrite and memDataOut held stable from the first MEM cycle until the ack or timeout edge.
  - memAck sampled 1 while in MEM:
    - read: the line is filled with memDataIn, its tag is set and it is marked valid; cacheDataRead=memDataIn.
    - write: the line is updated with the write data, its tag is set and it is marked valid (write-allocate).
    - either way memReq drops and the state goes to RESP.
  - Timeout: the counter increments on each MEM cycle without ack. When it reaches NXM_TIMEOUT:
    - memReq drops and nxmErr is set.
    - for a read, cacheDataRead=0; the line is not modified.
    - the state goes to RESP.
    - memAck on the same edge as the timeout takes priority: normal completion, no NXM.
- RESP:
  - mboxRespIn=1 for exactly one cycle, then the state goes to IDLE.
  - cacheDataRead holds its value until the next read response or reset. Writes do not change cacheDataRead.
- Busy rule: any EBOX_REQ sampled while in LOOKUP, MEM or RESP is dropped. cshEBOXRetry=1 for the next cycle. It is never queued.
- memAck outside MEM is ignored.
- nxmErr: nxmClr=1 clears it. If set and clear happen on the same edge, set wins.
- Latency, with the request sampled at edge E0:
  - cshEBOXT0 high in cycle E0+1.
  - read hit: mboxRespIn high in cycle E0+2.
  - miss or write: memReq first high in cycle E0+2; with the ack sampled at edge Ek, mboxRespIn is high in cycle Ek+1.
  - zero-wait memory (ack sampled at the first memReq edge): mboxRespIn in cycle E0+3.
- There is at most one outstanding request; exactly one response per accepted request (except on reset).

Test Plan:
- Reset then read VMA=0o123 with memory returning 0o777000111222 after 2 wait cycles:
  - cshEBOXT0 at E0+1; memReq from E0+2 with memAdr=0o123, memWrite=0.
  - mboxRespIn one cycle with cacheDataRead=0o777000111222.
- Repeat the same read:
  - hit; mboxRespIn at E0+2 with the same data.
  - memReq stays 0 throughout.
- Write VMA=0o123 data=0o1, then read VMA=0o123:
  - write: memReq with memWrite=1, memDataOut=0o1; mboxRespIn after ack.
  - read: hits at E0+2 returning 0o1, no memReq.
- Alias: read VMA=0o3 then VMA=0o23 (same index for LINES=16, different tag):
  - both miss and both issue memReq.
  - a third read of VMA=0o3 misses again.
- EBOX_REQ pulsed during MEM, and a separate request with eboxRead=eboxWrite=1 in IDLE:
  - each gives cshEBOXRetry for one cycle.
  - state and memReq are unaffected; no extra mboxRespIn.
- NXM and reset cases:
  - never ack a read: after NXM_TIMEOUT=63 memReq cycles memReq drops, nxmErr=1, mboxRespIn with data 0.
  - nxmClr clears nxmErr.
  - CROBAR_N=0 mid-MEM: all outputs 0 next cycle, no response, and the next read misses.

Source files
------------

// File: rtl/mbox_ebox_resp.sv
// ============================================================================
// Module  : mbox_ebox_resp
// Purpose : MBOX responder for EBOX word references with a direct-mapped,
//           write-through word cache and a req/ack memory port with NXM timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mbox_ebox_resp #(
    parameter int LINES       = 16,
    parameter int NXM_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        CROBAR_N,
    input  logic        EBOX_REQ,
    input  logic [13:35] EBOX_VMA,
    input  logic        eboxRead,
    input  logic        eboxWrite,
    input  logic [0:35] cacheDataWrite,
    output logic [0:35] cacheDataRead,
    output logic        mboxRespIn,
    output logic        cshEBOXT0,
    output logic        cshEBOXRetry,
    output logic        nxmErr,
    input  logic        nxmClr,
    output logic        memReq,
    output logic        memWrite,
    output logic [13:35] memAdr,
    output logic [0:35] memDataOut,
    input  logic [0:35] memDataIn,
    input  logic        memAck
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 23 - IDX_W;
    localparam int CNT_W = $clog2(NXM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NXM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MEM    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [22:0]        r_adr;
    logic [35:0]        r_wdata;
    logic               r_isWrite;
    logic [CNT_W-1:0]   r_cnt;

    logic [35:0]        r_lineData [LINES];
    logic [TAG_W-1:0]   r_lineTag  [LINES];
    logic [LINES-1:0]   r_valid;

    logic [35:0]        r_rdata;
    logic               r_resp;
    logic               r_t0;
    logic               r_retry;
    logic               r_nxm;
    logic               r_memReq;
    logic               r_memWrite;
    logic [22:0]        r_memAdr;
    logic [35:0]        r_memData;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_validOp;
    logic               w_timeout;

    assign w_idx     = r_adr[IDX_W-1:0];
    assign w_tag     = r_adr[22:IDX_W];
    assign w_hit     = r_valid[w_idx] && (r_lineTag[w_idx] == w_tag);
    assign w_validOp = eboxRead ^ eboxWrite;
    // An ack on the timeout edge wins, so the abort only fires without one.
    assign w_timeout = (r_state == ST_MEM) && !memAck && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!CROBAR_N) begin
            r_state    <= ST_IDLE;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_isWrite  <= 1'b0;
            r_cnt      <= '0;
            r_valid    <= '0;
            r_rdata    <= '0;
            r_resp     <= 1'b0;
            r_t0       <= 1'b0;
            r_retry    <= 1'b0;
            r_nxm      <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWrite <= 1'b0;
            r_memAdr   <= '0;
            r_memData  <= '0;
        end else begin
            r_t0    <= 1'b0;
            r_resp  <= 1'b0;
            r_retry <= EBOX_REQ && ((r_state != ST_IDLE) || !w_validOp);

            if (w_timeout)
                r_nxm <= 1'b1;
            else if (nxmClr)
                r_nxm <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (EBOX_REQ && w_validOp) begin
                        r_adr     <= EBOX_VMA;
                        r_wdata   <= cacheDataWrite;
                        r_isWrite <= eboxWrite;
                        r_t0      <= 1'b1;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!r_isWrite && w_hit) begin
                        r_rdata <= r_lineData[w_idx];
                        r_resp  <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_memReq   <= 1'b1;
                        r_memWrite <= r_isWrite;
                        r_memAdr   <= r_adr;
                        r_memData  <= r_wdata;
                        r_cnt      <= '0;
                        r_state    <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (memAck) begin
                        r_lineData[w_idx] <= r_isWrite ? r_wdata : memDataIn;
                        r_lineTag[w_idx]  <= w_tag;
                        r_valid[w_idx]    <= 1'b1;
                        if (!r_isWrite)
                            r_rdata <= memDataIn;
                        r_memReq <= 1'b0;
                        r_resp   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        if (!r_isWrite)
                            r_rdata <= '0;
                        r_memReq <= 1'b0;
                        r_resp   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cacheDataRead = r_rdata;
    assign mboxRespIn    = r_resp;
    assign cshEBOXT0     = r_t0;
    assign cshEBOXRetry  = r_retry;
    assign nxmErr        = r_nxm;
    assign memReq        = r_memReq;
    assign memWrite      = r_memWrite;
    assign memAdr        = r_memAdr;
    assign memDataOut    = r_memData;

endmodule

`default_nettype wire

// File: tb/tb_mbox_ebox_resp.sv
// ============================================================================
// Module  : tb_mbox_ebox_resp
// Purpose : Directed plus randomized bench for mbox_ebox_resp, checked against
//           an address-keyed cache/memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbox_ebox_resp;

    localparam int LINES = 16;
    localparam int NXM   = 63;

    logic         clk = 1'b0;
    logic         CROBAR_N;
    logic         EBOX_REQ;
    logic [13:35] EBOX_VMA;
    logic         eboxRead;
    logic         eboxWrite;
    logic [0:35]  cacheDataWrite;
    logic [0:35]  cacheDataRead;
    logic         mboxRespIn;
    logic         cshEBOXT0;
    logic         cshEBOXRetry;
    logic         nxmErr;
    logic         nxmClr;
    logic         memReq;
    logic         memWrite;
    logic [13:35] memAdr;
    logic [0:35]  memDataOut;
    logic [0:35]  memDataIn;
    logic         memAck;

    always #5 clk = ~clk;

    mbox_ebox_resp #(.LINES(LINES), .NXM_TIMEOUT(NXM)) u_dut (
        .clk            (clk),
        .CROBAR_N       (CROBAR_N),
        .EBOX_REQ       (EBOX_REQ),
        .EBOX_VMA       (EBOX_VMA),
        .eboxRead       (eboxRead),
        .eboxWrite      (eboxWrite),
        .cacheDataWrite (cacheDataWrite),
        .cacheDataRead  (cacheDataRead),
        .mboxRespIn     (mboxRespIn),
        .cshEBOXT0      (cshEBOXT0),
        .cshEBOXRetry   (cshEBOXRetry),
        .nxmErr         (nxmErr),
        .nxmClr         (nxmClr),
        .memReq         (memReq),
        .memWrite       (memWrite),
        .memAdr         (memAdr),
        .memDataOut     (memDataOut),
        .memDataIn      (memDataIn),
        .memAck         (memAck)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Reference model: each cache slot remembers the full word address it holds.
    logic [22:0] m_adr [LINES];
    logic [35:0] m_dat [LINES];
    bit          m_v   [LINES];
    logic [35:0] mem_model [int];
    logic [35:0] exp_rdata;
    bit          exp_nxm;

    function automatic logic [35:0] rnd36();
        return {4'($urandom()), $urandom()};
    endfunction

    function automatic int idx_of(input logic [22:0] a);
        return int'(a) % LINES;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
        exp_rdata = '0;
        exp_nxm   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, 64'(cacheDataRead), 64'(0));
        check({tag, "_ctl"}, 64'({mboxRespIn, cshEBOXT0, cshEBOXRetry, nxmErr, memReq, memWrite}), 64'(0));
        check({tag, "_adr"}, 64'(memAdr), 64'(0));
        check({tag, "_dout"}, 64'(memDataOut), 64'(0));
    endtask

    // waitc: memReq cycles before ack (-1 = never ack); poke/rst_at: memReq cycle index or -1.
    task automatic do_req(input bit wr, input logic [22:0] adr, input logic [35:0] wd,
                          input int waitc, input int poke, input int rst_at);
        bit hit, poked, done;
        int ix, resp_at;
        ix  = idx_of(adr);
        hit = !wr && m_v[ix] && (m_adr[ix] == adr);
        if (!mem_model.exists(int'(adr))) mem_model[int'(adr)] = rnd36();

        @(negedge clk);
        EBOX_REQ = 1'b1; EBOX_VMA = adr; eboxRead = !wr; eboxWrite = wr; cacheDataWrite = wd;
        @(negedge clk);
        EBOX_REQ = 1'b0; eboxRead = 1'b0; eboxWrite = 1'b0; cacheDataWrite = rnd36();
        check("t0", 64'(cshEBOXT0), 64'(1));
        check("t0_memreq", 64'(memReq), 64'(0));

        if (hit) begin
            @(negedge clk);
            exp_rdata = m_dat[ix];
            check("hit_resp", 64'(mboxRespIn), 64'(1));
            check("hit_data", 64'(cacheDataRead), 64'(exp_rdata));
            check("hit_nomem", 64'(memReq), 64'(0));
        end else begin
            resp_at = (waitc < 0) ? NXM : waitc + 1;
            poked = 1'b0;
            done  = 1'b0;
            for (int n = 0; n < NXM + 3; n++) begin
                @(negedge clk);
                memAck = 1'b0;
                memDataIn = rnd36();
                if (poked) begin
                    check("busy_retry", 64'(cshEBOXRetry), 64'(1));
                    EBOX_REQ = 1'b0; eboxRead = 1'b0; poked = 1'b0;
                end
                if (n == rst_at) begin
                    CROBAR_N = 1'b0;
                    @(negedge clk);
                    check_all_zero("midrst");
                    CROBAR_N = 1'b1;
                    model_reset();
                    done = 1'b1;
                    break;
                end
                if (n == resp_at) begin
                    if (waitc < 0) begin
                        exp_nxm = 1'b1;
                        if (!wr) exp_rdata = '0;
                    end else begin
                        m_v[ix] = 1'b1; m_adr[ix] = adr;
                        if (wr) mem_model[int'(adr)] = wd;
                        else    exp_rdata = mem_model[int'(adr)];
                        m_dat[ix] = mem_model[int'(adr)];
                    end
                    check("miss_resp", 64'(mboxRespIn), 64'(1));
                    check("miss_memreq_drop", 64'(memReq), 64'(0));
                    check("miss_data", 64'(cacheDataRead), 64'(exp_rdata));
                    check("miss_nxm", 64'(nxmErr), 64'(exp_nxm));
                    done = 1'b1;
                    break;
                end
                check("memreq", 64'(memReq), 64'(1));
                check("mem_noresp", 64'(mboxRespIn), 64'(0));
                check("mem_adr", 64'(memAdr), 64'(adr));
                check("mem_wr", 64'(memWrite), 64'(wr));
                if (wr) check("mem_dout", 64'(memDataOut), 64'(wd));
                if (n == waitc) begin
                    memAck = 1'b1;
                    memDataIn = wr ? rnd36() : mem_model[int'(adr)];
                end
                if (n == poke) begin
                    EBOX_REQ = 1'b1; eboxRead = 1'b1; EBOX_VMA = 23'(rnd36()); poked = 1'b1;
                end
            end
            if (!done) check("resp_bound", 64'(0), 64'(1));
        end
        @(negedge clk);
        memAck = 1'b0;
        check("post_noresp", 64'(mboxRespIn), 64'(0));
        check("post_nomem", 64'(memReq), 64'(0));
    endtask

    task automatic bad_req(input bit both);
        @(negedge clk);
        EBOX_REQ = 1'b1; EBOX_VMA = 23'(rnd36()); eboxRead = both; eboxWrite = both;
        @(negedge clk);
        EBOX_REQ = 1'b0; eboxRead = 1'b0; eboxWrite = 1'b0;
        check("bad_retry", 64'(cshEBOXRetry), 64'(1));
        check("bad_t0", 64'(cshEBOXT0), 64'(0));
        @(negedge clk);
        check("bad_quiet", 64'({cshEBOXRetry, memReq, mboxRespIn}), 64'(0));
    endtask

    task automatic pulse_clr();
        @(negedge clk); nxmClr = 1'b1;
        @(negedge clk); nxmClr = 1'b0;
        exp_nxm = 1'b0;
        check("nxm_clr", 64'(nxmErr), 64'(0));
    endtask

    initial begin
        CROBAR_N = 1'b0; EBOX_REQ = 1'b0; EBOX_VMA = '0; eboxRead = 1'b0; eboxWrite = 1'b0;
        cacheDataWrite = '0; nxmClr = 1'b0; memDataIn = '0; memAck = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        CROBAR_N = 1'b1;

        mem_model[int'(23'o123)] = 36'o777000111222;
        do_req(1'b0, 23'o123, '0, 2, -1, -1);
        check("tp_miss_data", 64'(cacheDataRead), 64'(36'o777000111222));
        do_req(1'b0, 23'o123, '0, 2, -1, -1);
        check("tp_hit_data", 64'(cacheDataRead), 64'(36'o777000111222));
        do_req(1'b1, 23'o123, 36'o1, 1, -1, -1);
        check("tp_wr_keeps", 64'(cacheDataRead), 64'(36'o777000111222));
        do_req(1'b0, 23'o123, '0, 0, -1, -1);
        check("tp_rd_after_wr", 64'(cacheDataRead), 64'(36'o1));

        do_req(1'b0, 23'o3,  '0, 0, -1, -1);
        do_req(1'b0, 23'o23, '0, 1, -1, -1);
        do_req(1'b0, 23'o3,  '0, 0, -1, -1);

        do_req(1'b0, 23'o40, '0, 4, 1, -1);
        bad_req(1'b1);
        bad_req(1'b0);

        do_req(1'b0, 23'o41, '0, NXM - 1, -1, -1);
        do_req(1'b0, 23'o42, '0, -1, 5, -1);
        pulse_clr();
        nxmClr = 1'b1;
        do_req(1'b1, 23'o44, 36'o55, -1, -1, -1);
        nxmClr = 1'b0;
        exp_nxm = 1'b0;

        do_req(1'b0, 23'o123, '0, 0, -1, -1);
        do_req(1'b0, 23'o43, '0, 5, -1, 2);
        do_req(1'b0, 23'o123, '0, 0, -1, -1);

        for (int t = 0; t < 150; t++) begin
            int w, p;
            if ($urandom_range(0, 9) == 0) begin
                bad_req(1'($urandom_range(0, 1)));
            end else begin
                w = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 4));
                p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (w < 0) ? 10 : w)) : -1;
                do_req(1'($urandom_range(0, 2) == 0), 23'($urandom_range(0, 63)), rnd36(), w, p, -1);
            end
            if ($urandom_range(0, 4) == 0) pulse_clr();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
